// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: accumulator FSM state encoding
// and the default product/accumulator widths.
package mac_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ACCUM = ST_ACCUM,
    S_DONE  = ST_DONE
  } state_t;

  localparam int DEF_PROD_W = 64;
  localparam int DEF_ACC_W  = 72;

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Combinational W-bit signed adder that clamps to the representable range
// and flags when a clamp happened.
module sat_adder #(
  parameter int W = 72
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                sat
);

  logic signed [W:0] w_full;

  assign w_full = {a[W-1], a} + {b[W-1], b};

  // Differing top two bits of the W+1-bit sum mean the true result left the W-bit range.
  always_comb begin
    sat = 1'b0;
    sum = w_full[W-1:0];
    if (w_full[W] != w_full[W-1]) begin
      sat = 1'b1;
      sum = w_full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates blocks of up to LEN signed products into a saturating ACC_W-bit
// sum and presents each block result over a valid/ready port.
module product_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN    = 8,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prod_valid,
  output logic                    prod_ready,
  input  logic [PROD_W-1:0]       prod_data,
  input  logic                    prod_last,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [ACC_W-1:0] res_data,
  output logic [CNT_W-1:0]        res_count,
  output logic                    res_ovf
);

  state_t                    r_state;
  logic signed [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]          r_count;
  logic                      r_ovf;

  logic signed [ACC_W-1:0]   w_ext;
  logic signed [ACC_W-1:0]   w_sum;
  logic                      w_sat;
  logic [CNT_W-1:0]          w_countNext;

  assign w_ext       = ACC_W'(signed'(prod_data));
  assign w_countNext = r_count + CNT_W'(1);

  sat_adder #(
    .W(ACC_W)
  ) u_satAdder (
    .a   (r_acc),
    .b   (w_ext),
    .sum (w_sum),
    .sat (w_sat)
  );

  // Handshake strobes depend on state only; both are forced low while reset is held.
  assign prod_ready = !rst && (r_state != S_DONE);
  assign res_valid  = !rst && (r_state == S_DONE);

  assign res_data  = r_acc;
  assign res_count = r_count;
  assign res_ovf   = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (prod_valid) begin
            r_acc   <= w_ext;
            r_count <= CNT_W'(1);
            r_ovf   <= 1'b0;
            r_state <= (prod_last || LEN == 1) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (prod_valid) begin
            r_acc   <= w_sum;
            r_count <= w_countNext;
            r_ovf   <= r_ovf | w_sat;
            if (prod_last || w_countNext == CNT_W'(LEN)) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Result registers stay frozen here until downstream takes them.
          if (res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: three instances cover LEN=4, LEN=8 with a
// narrow accumulator, and LEN=1 with a randomised scoreboard run.
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        prodValidA, prodLastA, resReadyA, prodReadyA, resValidA, resOvfA;
  logic [63:0] prodDataA;
  logic [71:0] resDataA;
  logic [7:0]  resCountA;

  logic        prodValidB, prodLastB, resReadyB, prodReadyB, resValidB, resOvfB;
  logic [63:0] prodDataB;
  logic [65:0] resDataB;
  logic [7:0]  resCountB;

  logic        prodValidC, prodLastC, resReadyC, prodReadyC, resValidC, resOvfC;
  logic [63:0] prodDataC;
  logic [71:0] resDataC;
  logic [7:0]  resCountC;

  int          checkCount = 0;
  int          passCount  = 0;
  int          sent, got, cycles;
  logic [71:0] expQ[$];
  logic [71:0] expVal;

  product_accumulator #(.PROD_W(64), .ACC_W(72), .LEN(4), .CNT_W(8)) dutA (
    .clk(clk), .rst(rst), .prod_valid(prodValidA), .prod_ready(prodReadyA),
    .prod_data(prodDataA), .prod_last(prodLastA), .res_valid(resValidA),
    .res_ready(resReadyA), .res_data(resDataA), .res_count(resCountA), .res_ovf(resOvfA));

  product_accumulator #(.PROD_W(64), .ACC_W(66), .LEN(8), .CNT_W(8)) dutB (
    .clk(clk), .rst(rst), .prod_valid(prodValidB), .prod_ready(prodReadyB),
    .prod_data(prodDataB), .prod_last(prodLastB), .res_valid(resValidB),
    .res_ready(resReadyB), .res_data(resDataB), .res_count(resCountB), .res_ovf(resOvfB));

  product_accumulator #(.PROD_W(64), .ACC_W(72), .LEN(1), .CNT_W(8)) dutC (
    .clk(clk), .rst(rst), .prod_valid(prodValidC), .prod_ready(prodReadyC),
    .prod_data(prodDataC), .prod_last(prodLastC), .res_valid(resValidC),
    .res_ready(resReadyC), .res_data(resDataC), .res_count(resCountC), .res_ovf(resOvfC));

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic applyStimulusA(input logic v, input logic [63:0] d, input logic l);
    prodValidA = v; prodDataA = d; prodLastA = l;
  endtask

  task automatic applyStimulusB(input logic v, input logic [63:0] d, input logic l);
    prodValidB = v; prodDataB = d; prodLastB = l;
  endtask

  task automatic applyStimulusC(input logic v, input logic [63:0] d, input logic l);
    prodValidC = v; prodDataC = d; prodLastC = l;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulusA(0, 0, 0); applyStimulusB(0, 0, 0); applyStimulusC(0, 0, 0);
    resReadyA = 1'b0; resReadyB = 1'b0; resReadyC = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst prodReady", prodReadyA, 0);
    checkOutput("rst resValid", resValidA, 0);
    rst = 1'b0;
    #1;
    checkOutput("post-rst resData", resDataA, 0);
    checkOutput("post-rst resCount", resCountA, 0);
    checkOutput("post-rst resOvf", resOvfA, 0);
    checkOutput("post-rst prodReady", prodReadyA, 1);

    // Test 1: LEN=4, 5,-3,7,1 back-to-back
    resReadyA = 1'b1;
    @(negedge clk); applyStimulusA(1, 64'd5, 0);
    @(negedge clk); applyStimulusA(1, -64'sd3, 0);
    @(negedge clk); applyStimulusA(1, 64'd7, 0);
    @(negedge clk); applyStimulusA(1, 64'd1, 0); #1;
    checkOutput("t1 resValid before last", resValidA, 0);
    @(negedge clk); applyStimulusA(0, 0, 0); #1;
    checkOutput("t1 resValid", resValidA, 1);
    checkOutput("t1 resData", resDataA, 10);
    checkOutput("t1 resCount", resCountA, 4);
    checkOutput("t1 resOvf", resOvfA, 0);
    checkOutput("t1 prodReady in done", prodReadyA, 0);
    @(negedge clk); #1;
    checkOutput("t1 resValid one cycle", resValidA, 0);
    checkOutput("t1 prodReady after", prodReadyA, 1);

    // Test 2a: LEN=8, ACC_W=66, eight 2^62 products saturate on the 8th add
    resReadyB = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); applyStimulusB(1, 64'h4000_0000_0000_0000, 0);
    end
    @(negedge clk); applyStimulusB(0, 0, 0); #1;
    checkOutput("t2 pos resValid", resValidB, 1);
    checkOutput("t2 pos resData", resDataB, 66'h1_FFFF_FFFF_FFFF_FFFF);
    checkOutput("t2 pos resCount", resCountB, 8);
    checkOutput("t2 pos resOvf", resOvfB, 1);

    // Test 3: early termination after two products, then a clean single-product block
    @(negedge clk); applyStimulusB(1, 64'd100, 0);
    @(negedge clk); applyStimulusB(1, 64'd200, 1);
    @(negedge clk); applyStimulusB(0, 0, 0); #1;
    checkOutput("t3 resValid", resValidB, 1);
    checkOutput("t3 resData", resDataB, 300);
    checkOutput("t3 resCount", resCountB, 2);
    checkOutput("t3 resOvf cleared", resOvfB, 0);
    @(negedge clk); applyStimulusB(1, 64'd9, 1);
    @(negedge clk); applyStimulusB(0, 0, 0); #1;
    checkOutput("t3 next resData", resDataB, 9);
    checkOutput("t3 next resCount", resCountB, 1);
    checkOutput("t3 next resOvf", resOvfB, 0);

    // Test 2b: eight -2^62 products land exactly on the minimum, no clamp
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); applyStimulusB(1, 64'hC000_0000_0000_0000, 0);
    end
    @(negedge clk); applyStimulusB(0, 0, 0); #1;
    checkOutput("t2 neg resValid", resValidB, 1);
    checkOutput("t2 neg resData", resDataB, 66'h2_0000_0000_0000_0000);
    checkOutput("t2 neg resCount", resCountB, 8);
    checkOutput("t2 neg resOvf", resOvfB, 0);

    // Test 4: result held while downstream stalls for 5 cycles
    resReadyA = 1'b0;
    @(negedge clk); applyStimulusA(1, 64'd10, 0);
    @(negedge clk); applyStimulusA(1, 64'd20, 0);
    @(negedge clk); applyStimulusA(1, 64'd30, 0);
    @(negedge clk); applyStimulusA(1, -64'sd5, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); applyStimulusA(1, 64'd999, 0); #1;
      checkOutput("t4 stall resValid", resValidA, 1);
      checkOutput("t4 stall resData", resDataA, 55);
      checkOutput("t4 stall resCount", resCountA, 4);
      checkOutput("t4 stall prodReady", prodReadyA, 0);
    end
    @(negedge clk); applyStimulusA(0, 0, 0); resReadyA = 1'b1; #1;
    checkOutput("t4 handoff resValid", resValidA, 1);
    checkOutput("t4 handoff resData", resDataA, 55);
    @(negedge clk); #1;
    checkOutput("t4 after resValid", resValidA, 0);
    checkOutput("t4 after prodReady", prodReadyA, 1);

    // Test 5: reset mid-block discards the partial sum
    @(negedge clk); applyStimulusA(1, 64'd7, 0);
    @(negedge clk); applyStimulusA(1, 64'd8, 0);
    @(negedge clk); applyStimulusA(0, 0, 0); rst = 1'b1; #1;
    checkOutput("t5 rst prodReady", prodReadyA, 0);
    checkOutput("t5 rst resValid", resValidA, 0);
    @(negedge clk); rst = 1'b0; #1;
    checkOutput("t5 resValid", resValidA, 0);
    checkOutput("t5 resData", resDataA, 0);
    checkOutput("t5 resCount", resCountA, 0);
    checkOutput("t5 resOvf", resOvfA, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); applyStimulusA(1, 64'd1, 0);
    end
    @(negedge clk); applyStimulusA(0, 0, 0); #1;
    checkOutput("t5 block resValid", resValidA, 1);
    checkOutput("t5 block resData", resDataA, 4);
    checkOutput("t5 block resCount", resCountA, 4);

    // Test 6: LEN=1 with random gaps and random downstream stalls, scoreboarded
    sent = 0; got = 0; cycles = 0;
    while ((sent < 100 || got < 100) && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (sent < 100 && $urandom_range(0, 2) != 0)
        applyStimulusC(1, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      else
        applyStimulusC(0, 0, 0);
      resReadyC = ($urandom_range(0, 3) != 0);
      #1;
      if (prodValidC && prodReadyC) begin
        expQ.push_back({{8{prodDataC[63]}}, prodDataC});
        sent++;
      end
      if (resValidC && resReadyC) begin
        if (expQ.size() == 0) begin
          checkOutput("t6 spurious result", 1, 0);
        end else begin
          expVal = expQ.pop_front();
          checkOutput("t6 resData", resDataC, expVal);
          checkOutput("t6 resCount", resCountC, 1);
        end
        got++;
      end
    end
    applyStimulusC(0, 0, 0);
    checkOutput("t6 results received", 128'(got), 100);
    checkOutput("t6 leftover products", 128'(expQ.size()), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
